// File: rtl/btn_counter_pkg.sv
// rtl/btn_counter_pkg.sv - shared level constants and debounce counter sizing for the button counter
package btn_counter_pkg;

  localparam logic LVL_RELEASED = 1'b0;
  localparam logic LVL_PRESSED  = 1'b1;

  // Stability counter width: enough bits to hold DB_CYCLES, never less than one bit.
  function automatic int db_cnt_width(input int db_cycles);
    int w;
    w = $clog2(db_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, optional debounce filter (BTN_DEBOUNCE_EN) and press detector
module btn_debounce
  import btn_counter_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  // Two-flop synchroniser on the inverted (active-high) button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= LVL_RELEASED;
      sync2_q <= LVL_RELEASED;
    end else begin
      sync1_q <= ~btn_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          db_q;
  logic          db_d;

  // Accept a new level only after DB_CYCLES consecutive mismatching cycles.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and stability counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= LVL_RELEASED;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign level = db_q;
`else
  // Without the filter the stability threshold has no effect.
  logic unused_db_cycles;
  assign unused_db_cycles = (DB_CYCLES > 0);
  assign level = sync2_q;
`endif

  // Remember the previous level so only the released-to-pressed transition fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= LVL_RELEASED;
    end else begin
      prev_q <= level;
    end
  end

  assign press_o = (level == LVL_PRESSED) && (prev_q == LVL_RELEASED);

endmodule

// File: rtl/btn_updown_counter.sv
// rtl/btn_updown_counter.sv - debounced up/down button counter with wrap or clamp; filter enabled by BTN_DEBOUNCE_EN
module btn_updown_counter
  import btn_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 100000,
  parameter int STEP      = 1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up_n,
  input  logic             btn_dn_n,
  output logic [WIDTH-1:0] count,
  output logic             limit
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  logic             up_ev;
  logic             dn_ev;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             limit_q;
  logic             limit_d;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_up_n),
    .press_o (up_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_dn_n),
    .press_o (dn_ev)
  );

  // Step arithmetic: the extra top bit flags carry out (up) or borrow (down).
  always_comb begin
    sum_w   = {1'b0, count_q} + STEP_W;
    diff_w  = {1'b0, count_q} - STEP_W;
    count_d = count_q;
    limit_d = 1'b0;
    if (up_ev && !dn_ev) begin
      count_d = sum_w[WIDTH-1:0];
      if (sum_w[WIDTH]) begin
        limit_d = 1'b1;
        if (SATURATE != 0) count_d = {WIDTH{1'b1}};
      end
    end else if (dn_ev && !up_ev) begin
      count_d = diff_w[WIDTH-1:0];
      if (diff_w[WIDTH]) begin
        limit_d = 1'b1;
        if (SATURATE != 0) count_d = '0;
      end
    end
  end

  // Counter and limit pulse registers; reset wins over any event.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  assign count = count_q;
  assign limit = limit_q;

endmodule
